// File: rtl/shift_arbiter.sv
// Shares one external 32-bit pipelined right-shift/rotate unit between two
// requesters. A round-robin arbiter picks at most one request per cycle.
// Left shifts and rotates are built from the right-only unit: the operand is
// bit-reversed on the way in and the result is bit-reversed on the way out.
// A tag pipeline, aligned with the shifter latency, sends each result back to
// the requester that issued it.
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   reqN_valid/ready/data/amt/op  request port N (op: 0=SRL 1=ROR 2=SLL 3=ROL)
//   rspN_valid/data               one-cycle result pulse for requester N
//   sh_a/sh_sel/sh_rotate         operand, amount and rotate enable to shifter
//   sh_b                          shifter result, LAT edges after sampling
//   busy                          ops in flight or a response pending
module shift_arbiter #(
  parameter int LAT  = 5,
  parameter int OP_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [31:0]     req0_data,
  input  logic [4:0]      req0_amt,
  input  logic [OP_W-1:0] req0_op,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [31:0]     req1_data,
  input  logic [4:0]      req1_amt,
  input  logic [OP_W-1:0] req1_op,
  output logic            rsp0_valid,
  output logic [31:0]     rsp0_data,
  output logic            rsp1_valid,
  output logic [31:0]     rsp1_data,
  output logic [31:0]     sh_a,
  output logic [4:0]      sh_sel,
  output logic            sh_rotate,
  input  logic [31:0]     sh_b,
  output logic            busy
);

  function automatic logic [31:0] bitrev(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  // rr_q names the requester that wins when both are valid.
  logic            rr_q, rr_d;
  logic            gnt_vld, gnt_id;
  logic [31:0]     sel_data;
  logic [4:0]      sel_amt;
  logic [OP_W-1:0] sel_op;

  logic [LAT-1:0]  tvld_q, tvld_d;
  logic [LAT-1:0]  tid_q, tid_d;
  logic [LAT-1:0]  trev_q, trev_d;

  logic            rsp0_vld_q, rsp0_vld_d;
  logic            rsp1_vld_q, rsp1_vld_d;
  logic [31:0]     rsp0_data_q, rsp0_data_d;
  logic [31:0]     rsp1_data_q, rsp1_data_d;
  logic [31:0]     res_fix;
  logic            busy_q, busy_d;

  // Stage p0: arbitration and combinational issue to the shifter
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (rst_n) begin
      if (req0_valid && req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = rr_q;
      end else if (req0_valid) begin
        gnt_vld = 1'b1;
      end else if (req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  assign req0_ready = gnt_vld && !gnt_id;
  assign req1_ready = gnt_vld &&  gnt_id;

  assign sel_data = gnt_id ? req1_data : req0_data;
  assign sel_amt  = gnt_id ? req1_amt  : req0_amt;
  assign sel_op   = gnt_id ? req1_op   : req0_op;

  assign sh_a      = gnt_vld ? (sel_op[1] ? bitrev(sel_data) : sel_data) : 32'd0;
  assign sh_sel    = gnt_vld ? sel_amt : 5'd0;
  assign sh_rotate = gnt_vld && sel_op[0];

  // Pointer flips to the other requester only when a transfer happens.
  assign rr_d = gnt_vld ? !gnt_id : rr_q;

  // Tag pipeline: stage 0 captures the issue, each stage advances every edge
  always_comb begin
    tvld_d    = tvld_q;
    tid_d     = tid_q;
    trev_d    = trev_q;
    tvld_d[0] = gnt_vld;
    tid_d[0]  = gnt_id;
    trev_d[0] = sel_op[1];
    for (int i = 1; i < LAT; i++) begin
      tvld_d[i] = tvld_q[i-1];
      tid_d[i]  = tid_q[i-1];
      trev_d[i] = trev_q[i-1];
    end
  end

  // Response stage: last tag stage lines up with sh_b
  assign res_fix     = trev_q[LAT-1] ? bitrev(sh_b) : sh_b;
  assign rsp0_vld_d  = tvld_q[LAT-1] && !tid_q[LAT-1];
  assign rsp1_vld_d  = tvld_q[LAT-1] &&  tid_q[LAT-1];
  assign rsp0_data_d = rsp0_vld_d ? res_fix : rsp0_data_q;
  assign rsp1_data_d = rsp1_vld_d ? res_fix : rsp1_data_q;
  assign busy_d      = (|tvld_d) || rsp0_vld_d || rsp1_vld_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q        <= 1'b0;
      tvld_q      <= '0;
      rsp0_vld_q  <= 1'b0;
      rsp1_vld_q  <= 1'b0;
      rsp0_data_q <= 32'd0;
      rsp1_data_q <= 32'd0;
      busy_q      <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      tvld_q      <= tvld_d;
      rsp0_vld_q  <= rsp0_vld_d;
      rsp1_vld_q  <= rsp1_vld_d;
      rsp0_data_q <= rsp0_data_d;
      rsp1_data_q <= rsp1_data_d;
      busy_q      <= busy_d;
    end
  end

  // Tag id/rev bits are qualified by tvld_q, so they need no reset.
  always_ff @(posedge clk) begin
    tid_q  <= tid_d;
    trev_q <= trev_d;
  end

  assign rsp0_valid = rsp0_vld_q;
  assign rsp1_valid = rsp1_vld_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign busy       = busy_q;

endmodule
